// File: rtl/cam_pkg.sv
// Shared timing defaults, RGB565 colour constants and pattern codes for the
// OV7670-style camera emulator.
package cam_pkg;

  localparam int DEF_LINE_BYTES = 320;
  localparam int DEF_ROWS       = 120;
  localparam int DEF_HBLANK     = 4;
  localparam int DEF_VBLANK     = 4;
  localparam int DEF_VSYNC_ROWS = 2;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  // The camera sends the high byte of each RGB565 pixel first.
  function automatic logic [7:0] rgb565_byte(input logic [15:0] px, input logic lo_byte);
    return lo_byte ? px[7:0] : px[15:8];
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: maps pixel coordinates, bar index and
// the latched pattern to the RGB565 byte for the current column parity.
module cam_pattern_gen
  import cam_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] bar,
  input  pattern_e   pattern,
  input  logic       lo_byte,
  output logic [7:0] data
);

  logic [15:0] px;

  always_comb begin
    px = RGB_RED;
    case (pattern)
      PAT_SOLID: px = RGB_RED;
      PAT_BARS: begin
        case (bar)
          3'd0: px = RGB_WHITE;
          3'd1: px = RGB_YELLOW;
          3'd2: px = RGB_CYAN;
          3'd3: px = RGB_GREEN;
          3'd4: px = RGB_MAGENTA;
          3'd5: px = RGB_RED;
          3'd6: px = RGB_BLUE;
          3'd7: px = RGB_BLACK;
        endcase
      end
      PAT_GRAD:  px = {x[7:3], 6'b000000, y[6:2]};
      PAT_CHECK: px = (x[3] ^ y[3]) ? RGB_BLACK : RGB_WHITE;
      default:   px = RGB_RED;
    endcase
  end

  assign data = rgb565_byte(px, lo_byte);

endmodule

// File: rtl/cam_emulator.sv
// OV7670-style camera source: pixel-clock divider, row/column timing, frame
// start gating on en, and registered vsync/href/pixel outputs.
module cam_emulator
  import cam_pkg::*;
#(
  parameter int PCLK_DIV   = 4,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ROWS       = DEF_ROWS,
  parameter int HBLANK     = DEF_HBLANK,
  parameter int VBLANK     = DEF_VBLANK,
  parameter int VSYNC_ROWS = DEF_VSYNC_ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern,
  output logic       cam_pclk,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_px_data,
  output logic       frame_done
);

  localparam int COLS      = LINE_BYTES + HBLANK;
  localparam int TROWS     = ROWS + VBLANK;
  localparam int BAR_BYTES = LINE_BYTES / 8;
  localparam int CW        = $clog2(COLS);
  localparam int RW        = $clog2(TROWS);
  localparam int DW        = $clog2(PCLK_DIV);
  localparam int BW        = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_ACTIVE = CW'(LINE_BYTES);
  localparam logic [RW-1:0] ROW_LAST   = RW'(TROWS - 1);
  localparam logic [RW-1:0] ROW_VSYNC  = RW'(VSYNC_ROWS);
  localparam logic [RW-1:0] ROW_VBLANK = RW'(VBLANK);
  localparam logic [DW-1:0] DIV_LAST   = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(PCLK_DIV / 2);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_BYTES - 1);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [BW-1:0] bar_byte, bar_byte_nxt;
  logic [2:0]    bar_idx, bar_idx_nxt;
  pattern_e      pat_q, pat_nxt;
  logic          upd, at_origin, advance, wrap;
  logic          vsync_nxt, href_nxt;
  logic [7:0]    x_nxt;
  logic [6:0]    y_nxt;
  logic [7:0]    byte_nxt;

  always_comb begin
    upd          = (div_cnt == DIV_LAST);
    div_nxt      = upd ? '0 : div_cnt + 1'b1;
    at_origin    = (row == '0) && (col == '0);
    // Sitting at (0,0) with en low is the idle state; en is only looked at here.
    advance      = upd && !(at_origin && !en);
    wrap         = advance && (row == ROW_LAST) && (col == COL_LAST);
    col_nxt      = col;
    row_nxt      = row;
    bar_byte_nxt = bar_byte;
    bar_idx_nxt  = bar_idx;
    pat_nxt      = pat_q;
    if (advance) begin
      if (at_origin) pat_nxt = pattern_e'(pattern);
      if (col == COL_LAST) begin
        col_nxt      = '0;
        row_nxt      = (row == ROW_LAST) ? '0 : row + 1'b1;
        bar_byte_nxt = '0;
        bar_idx_nxt  = '0;
      end else begin
        col_nxt = col + 1'b1;
        // Bar index tracks col / BAR_BYTES incrementally instead of dividing.
        if (bar_byte == BAR_LAST) begin
          bar_byte_nxt = '0;
          bar_idx_nxt  = bar_idx + 3'd1;
        end else begin
          bar_byte_nxt = bar_byte + 1'b1;
        end
      end
    end
    vsync_nxt = (row_nxt < ROW_VSYNC);
    href_nxt  = (row_nxt >= ROW_VBLANK) && (col_nxt < COL_ACTIVE);
    x_nxt     = 8'(col_nxt >> 1);
    y_nxt     = 7'(row_nxt - ROW_VBLANK);
  end

  cam_pattern_gen u_pattern_gen (
    .x       (x_nxt),
    .y       (y_nxt),
    .bar     (bar_idx_nxt),
    .pattern (pat_nxt),
    .lo_byte (col_nxt[0]),
    .data    (byte_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      bar_byte    <= '0;
      bar_idx     <= '0;
      pat_q       <= PAT_SOLID;
      cam_pclk    <= 1'b0;
      cam_vsync   <= 1'b1;
      cam_href    <= 1'b0;
      cam_px_data <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      cam_pclk   <= (div_nxt >= DIV_HALF);
      frame_done <= wrap;
      col        <= col_nxt;
      row        <= row_nxt;
      bar_byte   <= bar_byte_nxt;
      bar_idx    <= bar_idx_nxt;
      pat_q      <= pat_nxt;
      // Data outputs move only on the pclk falling edge so the receiver
      // sees them stable at the rising edge.
      if (upd) begin
        cam_vsync   <= vsync_nxt;
        cam_href    <= href_nxt;
        cam_px_data <= href_nxt ? byte_nxt : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_cam_emulator.sv
// Self-checking bench for cam_emulator on a reduced frame geometry, with a
// coordinate-level reference model tracking row/col/pattern per pclk.
module tb_cam_emulator;

  localparam int DIV = 4;
  localparam int LB  = 32;
  localparam int NR  = 20;
  localparam int HB  = 4;
  localparam int VB  = 4;
  localparam int VS  = 2;
  localparam int TCOLS     = LB + HB;
  localparam int TROWS     = NR + VB;
  localparam int FRAME_CLK = TCOLS * TROWS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       cam_pclk, cam_vsync, cam_href, frame_done;
  logic [7:0] cam_px_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] bar_rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  int m_row = 0;
  int m_col = 0;
  int m_pat = 0;
  bit m_wrap;

  cam_emulator #(
    .PCLK_DIV   (DIV),
    .LINE_BYTES (LB),
    .ROWS       (NR),
    .HBLANK     (HB),
    .VBLANK     (VB),
    .VSYNC_ROWS (VS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pattern     (pattern),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_px_data (cam_px_data),
    .frame_done  (frame_done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Reference pixel byte, computed straight from coordinates.
  function automatic logic [7:0] exp_byte(input int p, input int r, input int c);
    int x = c / 2;
    int y = r - VB;
    logic [15:0] px;
    case (p)
      0:       px = 16'hF800;
      1:       px = bar_rgb[x / (LB / 16)];
      2:       px = 16'(((x / 8) % 32) * 2048 + ((y / 4) % 32));
      3:       px = (((x / 8) % 2) == ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
      default: px = 16'h0000;
    endcase
    return (c % 2 == 0) ? px[15:8] : px[7:0];
  endfunction

  // Model advance at each pclk falling edge (the DUT update point).
  initial forever begin
    @(negedge cam_pclk or posedge rst);
    #1;
    if (rst) begin
      m_row = 0;
      m_col = 0;
      m_pat = 0;
    end else begin
      m_wrap = 1'b0;
      if (!(m_row == 0 && m_col == 0 && !en)) begin
        if (m_row == 0 && m_col == 0) m_pat = int'(pattern);
        m_wrap = (m_row == TROWS - 1) && (m_col == TCOLS - 1);
        m_col++;
        if (m_col == TCOLS) begin
          m_col = 0;
          m_row++;
          if (m_row == TROWS) m_row = 0;
        end
      end
      check("frame_done_at_update", frame_done, m_wrap);
    end
  end

  // Scoreboard at each pclk rising edge, where a receiver samples.
  initial forever begin
    logic exp_href;
    @(posedge cam_pclk);
    #1;
    exp_href = (m_row >= VB) && (m_col < LB);
    check("vsync", cam_vsync, (m_row < VS));
    check("href", cam_href, exp_href);
    check("px_data", cam_px_data, exp_href ? exp_byte(m_pat, m_row, m_col) : 8'h00);
    check("frame_done_idle", frame_done, 1'b0);
  end

  task automatic wait_frame_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame_done && cycles < budget);
    if (!frame_done) check("frame_done_timeout", frame_done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pclk"}, cam_pclk, 1'b0);
    check({tag, "_vsync"}, cam_vsync, 1'b1);
    check({tag, "_href"}, cam_href, 1'b0);
    check({tag, "_px"}, cam_px_data, 8'h00);
    check({tag, "_fd"}, frame_done, 1'b0);
  endtask

  initial begin
    int cyc;
    int w;
    int fd_cnt;

    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Divider runs with en low: period DIV, high for DIV/2.
    for (int k = 1; k <= 2 * DIV; k++) begin
      @(negedge clk);
      check("pclk_wave", cam_pclk, ((k % DIV) >= DIV / 2));
    end
    repeat (40) @(negedge clk);

    en = 1'b1;
    pattern = 2'd0;
    wait_frame_done(FRAME_CLK + 2 * DIV, cyc);

    // Every pattern, with a mid-frame pattern change that must not take effect.
    for (int i = 1; i <= 6; i++) begin
      pattern = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
      w = $urandom_range(16, 3000);
      repeat (w) @(negedge clk);
      pattern = 2'($urandom_range(0, 3));
      wait_frame_done(FRAME_CLK + 8, cyc);
      check("frame_period", w + cyc, FRAME_CLK);
    end

    // en dropped mid-frame: frame completes, then idle.
    w = $urandom_range(1200, 1800);
    repeat (w) @(negedge clk);
    en = 1'b0;
    wait_frame_done(FRAME_CLK + 8, cyc);
    check("en_drop_period", w + cyc, FRAME_CLK);
    fd_cnt = 0;
    repeat (2 * FRAME_CLK) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    check("idle_frame_done_count", fd_cnt, 0);
    check("idle_vsync", cam_vsync, 1'b1);
    check("idle_href", cam_href, 1'b0);

    // Reset mid-frame, then a full frame from (0,0).
    en = 1'b1;
    pattern = 2'd3;
    repeat (2000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    wait_frame_done(FRAME_CLK + 8, cyc);
    check("rst_restart_period", cyc, FRAME_CLK);

    en = 1'b0;
    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
